pwm_core: RTL and testbench

PWM_CORE -- requirements
Module: pwm_core

---
 rtl/pwm_core.sv | 150 +++++++++++++++
 tb/tb_pwm_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_core.sv
// Complementary PWM output stage with dead-time insertion and shadowed period/duty registers.
// The counter is external; this block compares it against the shadowed duty and sequences both outputs.
module pwm_core (
    input  logic        slow_clk,
    input  logic        rst,
    input  logic        counter_en,
    input  logic        mode,
    input  logic        out_en,
    input  logic        polarity,
    input  logic [15:0] counter,
    input  logic [15:0] period_reg,
    input  logic [15:0] duty_reg,
    input  logic [7:0]  deadtime,
    output logic        pwm_h,
    output logic        pwm_l,
    output logic        period_done
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_HIGH  = 3'd1;
    localparam logic [2:0] ST_DT_HL = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_DT_LH = 3'd4;

    logic [15:0] period_sh;
    logic [15:0] duty_sh;
    logic        raw_q;
    logic [2:0]  state_r;
    logic [7:0]  dt_cnt;

    logic        run_s;
    logic        load_s;
    logic        raw_s;
    logic        done_s;
    logic [2:0]  state_s;
    logic [7:0]  dt_cnt_s;

    // Run qualifier, shadow-load strobe, compare result and end-of-period detect.
    always_comb begin
        run_s  = mode && counter_en;
        load_s = !run_s || (counter == 16'd0);
        if (duty_sh == 16'd0) begin
            raw_s = 1'b0;
        end else if ((period_sh != 16'd0) && (duty_sh >= period_sh)) begin
            raw_s = 1'b1;
        end else begin
            raw_s = (counter < duty_sh);
        end
        // period_sh == 0 wraps to 0xFFFF, i.e. a 65536-count period.
        done_s = run_s && (counter == (period_sh - 16'd1));
    end

    // Dead-time sequencer next-state logic.
    always_comb begin
        state_s  = state_r;
        dt_cnt_s = dt_cnt;
        if (!(run_s && out_en)) begin
            state_s  = ST_OFF;
            dt_cnt_s = 8'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (!raw_q) begin
                        state_s = ST_LOW;
                    end else if (deadtime == 8'd0) begin
                        state_s = ST_HIGH;
                    end else begin
                        state_s  = ST_DT_LH;
                        dt_cnt_s = deadtime;
                    end
                end
                ST_HIGH: begin
                    if (raw_q) begin
                        state_s = ST_HIGH;
                    end else if (deadtime == 8'd0) begin
                        state_s = ST_LOW;
                    end else begin
                        state_s  = ST_DT_HL;
                        dt_cnt_s = deadtime;
                    end
                end
                ST_LOW: begin
                    if (!raw_q) begin
                        state_s = ST_LOW;
                    end else if (deadtime == 8'd0) begin
                        state_s = ST_HIGH;
                    end else begin
                        state_s  = ST_DT_LH;
                        dt_cnt_s = deadtime;
                    end
                end
                ST_DT_HL: begin
                    if (raw_q) begin
                        state_s  = ST_HIGH;
                        dt_cnt_s = 8'd0;
                    end else if (dt_cnt <= 8'd1) begin
                        state_s  = ST_LOW;
                        dt_cnt_s = 8'd0;
                    end else begin
                        dt_cnt_s = dt_cnt - 8'd1;
                    end
                end
                ST_DT_LH: begin
                    if (!raw_q) begin
                        state_s  = ST_LOW;
                        dt_cnt_s = 8'd0;
                    end else if (dt_cnt <= 8'd1) begin
                        state_s  = ST_HIGH;
                        dt_cnt_s = 8'd0;
                    end else begin
                        dt_cnt_s = dt_cnt - 8'd1;
                    end
                end
                default: begin
                    state_s  = ST_OFF;
                    dt_cnt_s = 8'd0;
                end
            endcase
        end
    end

    // State, shadows, compare and registered outputs; outputs decode the next state so they never overlap.
    always_ff @(posedge slow_clk) begin
        if (rst) begin
            state_r     <= ST_OFF;
            dt_cnt      <= 8'd0;
            raw_q       <= 1'b0;
            period_sh   <= 16'd0;
            duty_sh     <= 16'd0;
            period_done <= 1'b0;
            pwm_h       <= polarity;
            pwm_l       <= polarity;
        end else begin
            state_r     <= state_s;
            dt_cnt      <= dt_cnt_s;
            raw_q       <= raw_s;
            period_done <= done_s;
            if (load_s) begin
                period_sh <= period_reg;
                duty_sh   <= duty_reg;
            end else begin
                period_sh <= period_sh;
                duty_sh   <= duty_sh;
            end
            pwm_h <= (state_s == ST_HIGH) ? !polarity : polarity;
            pwm_l <= (state_s == ST_LOW)  ? !polarity : polarity;
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: table of steady-state duty/dead-time cases plus corner sequences.
module tb_pwm_core;

    logic        slow_clk = 1'b0;
    logic        rst = 1'b1;
    logic        counter_en = 1'b0;
    logic        mode = 1'b0;
    logic        out_en = 1'b0;
    logic        polarity = 1'b0;
    logic [15:0] counter = 16'd0;
    logic [15:0] period_reg = 16'd0;
    logic [15:0] duty_reg = 16'd0;
    logic [7:0]  deadtime = 8'd0;
    logic        pwm_h;
    logic        pwm_l;
    logic        period_done;

    pwm_core dut (
        .slow_clk    (slow_clk),
        .rst         (rst),
        .counter_en  (counter_en),
        .mode        (mode),
        .out_en      (out_en),
        .polarity    (polarity),
        .counter     (counter),
        .period_reg  (period_reg),
        .duty_reg    (duty_reg),
        .deadtime    (deadtime),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .period_done (period_done)
    );

    always #5 slow_clk = ~slow_clk;

    typedef struct {
        logic [15:0] period;
        logic [15:0] duty;
        logic [7:0]  dt;
        logic        pol;
        int          exp_h;
        int          exp_l;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    logic [15:0] h1 = 16'd0;
    logic [15:0] h2 = 16'd0;
    logic [15:0] rel2;
    logic [15:0] rel1;
    logic s_h, s_l, s_d;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample outputs at the falling edge, then drive the next counter value.
    // rel2 is the counter driven two calls ago (what pwm_h/pwm_l reflect), rel1 the one before (period_done).
    task automatic cyc(input logic [15:0] c);
        @(negedge slow_clk);
        s_h  = pwm_h;
        s_l  = pwm_l;
        s_d  = period_done;
        rel2 = h2;
        rel1 = h1;
        if ((s_h != polarity) && (s_l != polarity)) overlap++;
        h2 = h1;
        h1 = c;
        counter = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(16'd0);
        cyc(16'd0);
        rst = 1'b0;
    endtask

    task automatic setup(input logic [15:0] p, input logic [15:0] d, input logic [7:0] dt, input logic pol);
        period_reg = p;
        duty_reg   = d;
        deadtime   = dt;
        polarity   = pol;
        mode       = 1'b1;
        counter_en = 1'b1;
        out_en     = 1'b1;
        do_reset();
    endtask

    task automatic run_periods(input int n, input int p);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++)
                cyc(16'(i));
    endtask

    initial begin
        int ch, cl, cd, old_cnt, new_cnt;

        vecs[0] = '{16'd10, 16'd3,  8'd0, 1'b0, 3, 7,  1};
        vecs[1] = '{16'd10, 16'd5,  8'd2, 1'b0, 3, 3,  1};
        vecs[2] = '{16'd10, 16'd0,  8'd0, 1'b0, 0, 10, 1};
        vecs[3] = '{16'd10, 16'd12, 8'd0, 1'b0, 10, 0, 1};
        vecs[4] = '{16'd10, 16'd2,  8'd4, 1'b0, 0, 8,  1};
        vecs[5] = '{16'd10, 16'd3,  8'd0, 1'b1, 3, 7,  1};
        vecs[6] = '{16'd8,  16'd3,  8'd1, 1'b0, 2, 4,  1};

        // Reset state with polarity 0: everything inactive low.
        rst = 1'b1;
        cyc(16'd0);
        cyc(16'd0);
        check("reset_h", int'(pwm_h), 0);
        check("reset_l", int'(pwm_l), 0);
        check("reset_done", int'(period_done), 0);

        // Steady-state active counts over one period.
        for (int v = 0; v < 7; v++) begin
            setup(vecs[v].period, vecs[v].duty, vecs[v].dt, vecs[v].pol);
            run_periods(3, int'(vecs[v].period));
            ch = 0; cl = 0; cd = 0; overlap = 0;
            for (int i = 0; i < int'(vecs[v].period); i++) begin
                cyc(16'(i));
                if (s_h != vecs[v].pol) ch++;
                if (s_l != vecs[v].pol) cl++;
                if (s_d) cd++;
            end
            check($sformatf("vec%0d_h_count", v), ch, vecs[v].exp_h);
            check($sformatf("vec%0d_l_count", v), cl, vecs[v].exp_l);
            check($sformatf("vec%0d_done_count", v), cd, vecs[v].exp_done);
            check($sformatf("vec%0d_overlap", v), overlap, 0);
        end

        // Cycle-exact 2-cycle latency, period 10 duty 3 no dead-time.
        setup(16'd10, 16'd3, 8'd0, 1'b0);
        run_periods(3, 10);
        for (int i = 0; i < 20; i++) begin
            cyc(16'(i % 10));
            check("lat_h", int'(s_h), (rel2 < 16'd3) ? 1 : 0);
            check("lat_l", int'(s_l), (rel2 < 16'd3) ? 0 : 1);
            check("lat_done", int'(s_d), (rel1 == 16'd9) ? 1 : 0);
        end

        // Duty 3 -> 7 written while counter is 5: old tail stays at 3, next period shows 7.
        setup(16'd10, 16'd3, 8'd0, 1'b0);
        run_periods(3, 10);
        for (int i = 0; i < 5; i++) cyc(16'(i));
        duty_reg = 16'd7;
        old_cnt = 0; new_cnt = 0;
        for (int j = 0; j < 17; j++) begin
            cyc(16'((j + 5) % 10));
            if (j < 7) begin
                if (s_h) old_cnt++;
            end else begin
                if (s_h) new_cnt++;
            end
        end
        check("midwrite_old_tail_h", old_cnt, 0);
        check("midwrite_new_period_h", new_cnt, 7);

        // Reset asserted mid DT_LH with active-low outputs, then resume from OFF.
        setup(16'd10, 16'd5, 8'd4, 1'b1);
        run_periods(3, 10);
        cyc(16'd0);
        cyc(16'd1);
        rst = 1'b1;
        cyc(16'd2);
        check("dtlh_idle_h", int'(s_h), 1);
        check("dtlh_idle_l", int'(s_l), 1);
        cyc(16'd3);
        rst = 1'b0;
        check("rst_dt_h", int'(s_h), 1);
        check("rst_dt_l", int'(s_l), 1);
        check("rst_dt_done", int'(s_d), 0);
        cyc(16'd4);
        cyc(16'd5);
        check("resume_h", int'(s_h), 1);
        check("resume_l", int'(s_l), 0);

        // out_en low forces both outputs to the idle level.
        out_en = 1'b0;
        cyc(16'd6);
        cyc(16'd7);
        check("outen_h", int'(s_h), 1);
        check("outen_l", int'(s_l), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
